// File: rtl/prng.sv
// 43-bit Fibonacci LFSR random generator (x^43+x^42+x^38+x^37+1) that leaps
// OUT_size steps per fetch and presents the top OUT_size state bits as a sample.
module prng #(
  parameter int LFSR_size = 43,
  parameter int OUT_size  = 32
) (
  input  logic [LFSR_size-1:0] initSeed,
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enablePRNG,
  input  logic                 fetchNewSample,
  output logic [OUT_size-1:0]  randomArray
);

  typedef enum logic {
    UNSEEDED = 1'b0,
    RUN      = 1'b1
  } state_t;

  localparam logic [LFSR_size-1:0] ONE = {{(LFSR_size-1){1'b0}}, 1'b1};

  state_t               r_state;
  logic [LFSR_size-1:0] r_lfsr;
  logic [OUT_size-1:0]  r_out;
  logic [LFSR_size-1:0] w_leap;
  logic [LFSR_size-1:0] w_seed;
  logic                 w_fetch;

  // Unrolled leap-forward: OUT_size single steps chained in one cycle.
  function automatic logic [LFSR_size-1:0] leap(input logic [LFSR_size-1:0] s);
    logic [LFSR_size-1:0] t;
    logic                 fb;
    t = s;
    for (int i = 0; i < OUT_size; i++) begin
      fb = t[LFSR_size-1] ^ t[LFSR_size-2] ^ t[LFSR_size-6] ^ t[LFSR_size-7];
      t  = {t[LFSR_size-2:0], fb};
    end
    return t;
  endfunction

  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  assign w_seed  = (initSeed == '0) ? ONE : initSeed;
  assign w_leap  = leap(r_lfsr);
  assign w_fetch = enablePRNG & fetchNewSample;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= UNSEEDED;
      r_lfsr  <= ONE;
      r_out   <= '0;
    end else begin
      case (r_state)
        UNSEEDED: begin
          r_lfsr  <= w_seed;
          r_state <= RUN;
        end
        RUN: begin
          if (w_fetch) begin
            r_lfsr <= w_leap;
            r_out  <= w_leap[LFSR_size-1 -: OUT_size];
          end
        end
        default: r_state <= UNSEEDED;
      endcase
    end
  end

  assign randomArray = r_out;

endmodule

// File: tb/tb_prng.sv
// Randomized self-checking bench for prng against an arithmetic LFSR model.
module tb_prng;

  localparam longint unsigned ALL43 = 64'h0000_07FF_FFFF_FFFF;
  localparam longint unsigned TAPS  = 64'h0000_0630_0000_0000;

  logic [42:0] seed;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        en = 1'b0;
  logic        fetch = 1'b0;
  logic [31:0] out;

  int checks = 0;
  int failures = 0;
  longint unsigned m_s;

  always #5 clock = ~clock;

  prng #(.LFSR_size(43), .OUT_size(32)) dut (
    .initSeed      (seed),
    .clock         (clock),
    .reset         (reset),
    .enablePRNG    (en),
    .fetchNewSample(fetch),
    .randomArray   (out)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Model: 43-bit value, feedback is parity of the tapped bits, shifted in at bit 0.
  function automatic longint unsigned step32(input longint unsigned s);
    longint unsigned t;
    longint unsigned fb;
    t = s;
    for (int i = 0; i < 32; i++) begin
      fb = longint'($countones(t & TAPS) % 2);
      t  = ((t << 1) | fb) & ALL43;
    end
    return t;
  endfunction

  function automatic longint unsigned sample_of(input longint unsigned s);
    return (s >> 11) & 64'hFFFF_FFFF;
  endfunction

  function automatic void m_load(input logic [42:0] sd);
    m_s = (sd == 43'd0) ? 64'd1 : {21'd0, sd};
  endfunction

  function automatic longint unsigned m_adv();
    m_s = step32(m_s);
    return sample_of(m_s);
  endfunction

  function automatic bit balanced(input logic [42:0] sd);
    longint unsigned s;
    int ones[32];
    s = (sd == 43'd0) ? 64'd1 : {21'd0, sd};
    for (int b = 0; b < 32; b++) ones[b] = 0;
    for (int n = 0; n < 1000; n++) begin
      s = step32(s);
      for (int b = 0; b < 32; b++) ones[b] += int'((s >> (11 + b)) & 1);
    end
    for (int b = 0; b < 32; b++)
      if (ones[b] < 450 || ones[b] > 550) return 1'b0;
    return 1'b1;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [42:0] rseed;
    logic [31:0] first;
    logic [31:0] exp;
    logic [63:0] r64;
    int          ones[32];

    // Reset and seed 1, generator disabled
    seed = 43'd1;
    #3 chk("rst_out", {32'd0, out}, 64'd0);
    tick();
    tick();
    reset = 1'b1;
    m_load(seed);
    tick();
    chk("seed_edge", {32'd0, out}, 64'd0);
    for (int i = 0; i < 5; i++) begin
      fetch = 1'b1;
      tick();
      chk("dis_fetch", {32'd0, out}, 64'd0);
      fetch = 1'b0;
      tick();
    end

    en = 1'b1;
    fetch = 1'b1;
    tick();
    exp = 32'(m_adv());
    chk("first_s1", {32'd0, out}, 64'h0020_0000);
    fetch = 1'b0;
    tick();
    chk("hold_s1", {32'd0, out}, 64'h0020_0000);
    for (int i = 0; i < 4; i++) begin
      fetch = 1'b1;
      tick();
      exp = 32'(m_adv());
      chk("seq_s1", {32'd0, out}, {32'd0, exp});
      fetch = 1'b0;
      tick();
      chk("hold_seq", {32'd0, out}, {32'd0, exp});
    end

    // Seed 0, fetch held high through the seed-load edge and beyond
    reset = 1'b0;
    #1 chk("rst_async", {32'd0, out}, 64'd0);
    tick();
    reset = 1'b1;
    seed = 43'd0;
    m_load(seed);
    en = 1'b1;
    fetch = 1'b1;
    tick();
    chk("unseeded_fetch", {32'd0, out}, 64'd0);
    tick();
    exp = 32'(m_adv());
    chk("seed0", {32'd0, out}, 64'h0020_0000);
    for (int i = 0; i < 4; i++) begin
      tick();
      exp = 32'(m_adv());
      chk("burst", {32'd0, out}, {32'd0, exp});
    end
    en = 1'b0;
    tick();
    chk("en_low_hold", {32'd0, out}, {32'd0, exp});
    fetch = 1'b0;
    en = 1'b1;

    // Random seed, 1000 pulses, seed disturbed while running
    r64 = {$urandom, $urandom};
    rseed = r64[42:0];
    for (int k = 0; k < 16 && !balanced(rseed); k++) begin
      r64 = {$urandom, $urandom};
      rseed = r64[42:0];
    end
    reset = 1'b0;
    #1;
    tick();
    reset = 1'b1;
    seed = rseed;
    m_load(rseed);
    tick();
    for (int b = 0; b < 32; b++) ones[b] = 0;
    first = 32'd0;
    for (int n = 0; n < 1000; n++) begin
      fetch = 1'b1;
      en = 1'b1;
      tick();
      exp = 32'(m_adv());
      if (n == 0) first = exp;
      chk("rand_sample", {32'd0, out}, {32'd0, exp});
      for (int b = 0; b < 32; b++) ones[b] += int'(out[b]);
      r64 = {$urandom, $urandom};
      seed = r64[42:0];
      if ($urandom_range(1, 0) == 1) begin
        fetch = 1'b1;
        en = 1'b0;
      end else begin
        fetch = 1'b0;
        en = 1'b1;
      end
      tick();
      chk("rand_hold", {32'd0, out}, {32'd0, exp});
    end
    for (int b = 0; b < 32; b++)
      chk($sformatf("density_bit%0d", b),
          {63'd0, (ones[b] >= 450 && ones[b] <= 550)}, 64'd1);

    // Reset between pulses, then replay the first sample of the sequence
    fetch = 1'b0;
    en = 1'b1;
    #2 reset = 1'b0;
    #1 chk("rst_mid", {32'd0, out}, 64'd0);
    tick();
    reset = 1'b1;
    seed = rseed;
    tick();
    chk("post_rst_idle", {32'd0, out}, 64'd0);
    fetch = 1'b1;
    tick();
    chk("replay_first", {32'd0, out}, {32'd0, first});
    fetch = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/prng.md
PRNG -- requirements
Module: prng

Interface
REQ-001 Parameter LFSR_size, default 43, state register width; only 43 is required.
REQ-002 Parameter OUT_size, default 32, width of randomArray; must be <= LFSR_size.
REQ-003 clock  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (asserted at 0).
REQ-005 initSeed  input  LFSR_size  seed value, sampled once after reset release.
REQ-006 enablePRNG  input  1  generator enable; while 0, fetch requests are ignored.
REQ-007 fetchNewSample  input  1  request for a new sample, acted on at a rising edge while high.
REQ-008 randomArray  output  OUT_size  registered random sample.
REQ-009 Port order SHALL be: initSeed, clock, reset, enablePRNG, fetchNewSample, randomArray.

Function
REQ-010 The state SHALL be a LFSR_size-bit Fibonacci LFSR with polynomial x^43+x^42+x^38+x^37+1.
- Step: fb = s[42]^s[41]^s[37]^s[36].
- s <= {s[41:0], fb}.
REQ-011 The block SHALL have two control states: UNSEEDED and RUN.
REQ-012 In UNSEEDED, the first rising edge SHALL load the LFSR and enter RUN.
- Loaded value is initSeed.
- If initSeed is all zeros, load the constant 43'h1 instead.
- randomArray is unchanged on this edge.
REQ-013 In RUN, if enablePRNG=1 and fetchNewSample=1 at a rising edge:
- The LFSR SHALL advance exactly OUT_size (32) steps in that single cycle, computed combinationally as unrolled leap-forward.
- randomArray SHALL take the new LFSR[42:11] (top OUT_size bits) on the same edge.
- Latency is one edge; the value is stable from the next clock onward.
REQ-014 In RUN, if enablePRNG=0 or fetchNewSample=0, the LFSR and randomArray SHALL hold.
REQ-015 A fetchNewSample held high for N consecutive edges with enablePRNG=1 SHALL produce N successive advances, one per edge.
REQ-016 A fetch occurring on the UNSEEDED edge SHALL be ignored; only the seed load happens.
REQ-017 The LFSR SHALL never reach the all-zero state during operation.
REQ-018 Changes to initSeed while in RUN SHALL have no effect.
REQ-019 The design SHALL be fully synchronous except for the reset, and free of latches.

Reset
REQ-020 While reset=0, the following SHALL hold immediately and asynchronously:
- randomArray = 0.
- LFSR = 43'h1.
- State = UNSEEDED.
REQ-021 Reset asserted mid-operation SHALL abort all activity.
- After release, the next rising edge reloads initSeed per REQ-012.
REQ-022 Reset release needs no synchronizer inside the block; the integrator supplies a synchronously deasserted reset.

Verification
REQ-023 Scenario: assert reset=0, then release.
- randomArray = 0 during reset and after the first edge.
REQ-024 Scenario: seed 43'h1, enablePRNG=0, 5 fetch pulses (1 cycle high, 1 low).
- randomArray stays 0.
- LFSR stays 43'h1.
REQ-025 Scenario: seed 43'h1, enablePRNG=1, one fetch pulse.
- randomArray = 32'h00200000 (LFSR = 2^32).
- Subsequent pulses match a bit-accurate software model stepping 32 times per pulse.
REQ-026 Scenario: seed 0, enablePRNG=1, one fetch.
- Output is identical to the seed-43'h1 case, 32'h00200000.
REQ-027 Scenario: random seed, 1000 fetch pulses with enablePRNG=1.
- Every sample matches the model.
- No LFSR value is all zeros.
- Sample mean bit density is between 0.45 and 0.55 per bit position.
REQ-028 Scenario: reset asserted between fetch pulses.
- randomArray returns to 0 at once.
- After release and one idle edge, the first fetch reproduces the first sample of the original sequence for the same seed.
